// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the multi-cycle RV32I core.
// Owns the architectural PC, issues one imem request at a time and hands
// each fetched word to decode over a valid/ready handshake. Redirects
// squash any in-flight fetch; a misaligned redirect target parks the block
// in a terminal FAULT state until reset.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no fetch outstanding; start one when stall=0
//   REQ   | imem_req held with latched imem_addr until imem_gnt
//   WAIT  | request granted, waiting for imem_rvalid
//   HOLD  | word presented to decode, waiting for if_ready
//   FAULT | misaligned redirect seen; inert until reset
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  // Set when the response of the outstanding request belongs to a squashed
  // fetch and must be thrown away.
  logic        drop;

  logic redirect_misaligned;
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Fetch FSM, PC and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= 32'h0;
      if_pc     <= 32'h0;
      fault     <= 1'b0;
      fault_pc  <= 32'h0;
    end else if (state != FAULT) begin
      if (redirect_misaligned) begin
        // pc is left alone; whatever imem returns later is never looked at.
        state    <= FAULT;
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
        imem_req <= 1'b0;
        if_valid <= 1'b0;
        drop     <= 1'b0;
      end else if (redirect_valid) begin
        pc <= redirect_pc;
        case (state)
          HOLD: begin
            // A same-cycle handshake is treated as consumed, but the
            // redirect target replaces pc+4.
            if_valid <= 1'b0;
            state    <= IDLE;
          end
          REQ: begin
            // imem_addr keeps the old address until the grant; only its
            // response is discarded.
            drop <= 1'b1;
            if (imem_gnt) begin
              imem_req <= 1'b0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            // If the response lands in the same cycle it is the one being
            // squashed, so discard it now instead of waiting for another
            // response that will never come.
            if (imem_rvalid) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              drop <= 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (!stall) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          REQ: begin
            if (imem_gnt) begin
              imem_req <= 1'b0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= IDLE;
              end else begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_valid <= 1'b1;
                state    <= HOLD;
              end
            end
          end
          HOLD: begin
            if (if_ready) begin
              if_valid <= 1'b0;
              pc       <= pc + 32'd4;
              state    <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: imem and decode are driven by hand, one
// cycle at a time, with expected values written out as constants.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    step(); step(); step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);

    // 1. back-to-back fetches, gnt same cycle, rvalid one cycle later
    rst_n = 1'b1;
    step();
    chk("t1_req0", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    step();
    chk("t1_req_drop", {31'b0, imem_req}, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    chk("t1_valid0", {31'b0, if_valid}, 32'd1);
    chk("t1_instr0", if_instr, 32'h0000_0013);
    chk("t1_pc0", if_pc, 32'h0);
    step();
    chk("t1_once0", {31'b0, if_valid}, 32'd0);
    step();
    chk("t1_req1", {31'b0, imem_req}, 32'd1);
    chk("t1_addr1", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
    step();
    imem_rvalid = 1'b0;
    chk("t1_instr1", if_instr, 32'h0010_0093);
    chk("t1_pc1", if_pc, 32'h4);
    step();
    chk("t1_once1", {31'b0, if_valid}, 32'd0);

    // 2. grant withheld five cycles; 3. decode back-pressure four cycles
    if_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_held", {31'b0, imem_req}, 32'd1);
      chk("t2_addr_held", imem_addr, 32'h8);
      step();
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_0113;
    step();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid_held", {31'b0, if_valid}, 32'd1);
      chk("t3_instr_held", if_instr, 32'h0020_0113);
      chk("t3_pc_held", if_pc, 32'h8);
      chk("t3_no_req", {31'b0, imem_req}, 32'd0);
      step();
    end
    if_ready = 1'b1;
    step();
    chk("t3_released", {31'b0, if_valid}, 32'd0);
    step();
    chk("t3_next_addr", imem_addr, 32'hC);

    // 4. redirect during WAIT discards the returning word
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("t4_discard", {31'b0, if_valid}, 32'd0);
    step();
    chk("t4_discard2", {31'b0, if_valid}, 32'd0);
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193;
    step();
    imem_rvalid = 1'b0;
    chk("t4_if_pc", if_pc, 32'h100);
    chk("t4_instr", if_instr, 32'h0030_0193);
    step();

    // 6b. redirect together with handshake in HOLD: target wins over +4
    if_ready = 1'b0;
    step();
    chk("t6_addr104", imem_addr, 32'h104);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0040_0213;
    step();
    imem_rvalid = 1'b0;
    chk("t6_hold", {31'b0, if_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; if_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("t6_redir_drop_valid", {31'b0, if_valid}, 32'd0);
    step();
    chk("t6_redir_addr", imem_addr, 32'hFFFF_FFFC);

    // 6a. wrap of pc past 0xFFFF_FFFC, with stall holding off the next fetch
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0293;
    step();
    imem_rvalid = 1'b0;
    chk("t6_wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("t6_wrap_req", {31'b0, imem_req}, 32'd1);
    chk("t6_wrap_addr", imem_addr, 32'h0);

    // redirect in REQ without grant: old address held until granted
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("rq_req_held", {31'b0, imem_req}, 32'd1);
    chk("rq_addr_old", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAAD_F00D;
    step();
    imem_rvalid = 1'b0;
    chk("rq_discard", {31'b0, if_valid}, 32'd0);
    step();
    chk("rq_new_addr", imem_addr, 32'h200);

    // 5. misaligned redirect -> sticky fault, everything else ignored
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("t5_fault", {31'b0, fault}, 32'd1);
    chk("t5_fault_pc", fault_pc, 32'h102);
    chk("t5_no_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    chk("t5_rvalid_ignored", {31'b0, if_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("t5_still_no_req", {31'b0, imem_req}, 32'd0);
    chk("t5_sticky", {31'b0, fault}, 32'd1);
    chk("t5_fault_pc_kept", fault_pc, 32'h102);

    // reset out of FAULT restarts from RESET_PC
    rst_n = 1'b0;
    step();
    chk("rst2_fault", {31'b0, fault}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst2_req", {31'b0, imem_req}, 32'd1);
    chk("rst2_req_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
